// File: rtl/lfsr_checker.sv
// lfsr_checker: hunts for and tracks a 5-bit pseudo-random word stream, counting errors while locked.
// Define LFSR_CHK_BITCNT_EN to count mismatching bits instead of mismatching words.
module lfsr_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [4:0]  in_data,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_cnt
);
  typedef enum logic {HUNT, LOCKED} state_t;
  localparam logic [3:0] LOCK_LAST   = 4'(LOCK_CNT - 1);
  localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_CNT - 1);
  state_t state, state_nx;
  logic seeded, seeded_nx, pulse_nx;
  logic [3:0] match_cnt, match_nx, miss_cnt, miss_nx;
  logic [4:0] prev, prev_nx, expected, exp_nx;
  logic [15:0] cnt_nx;
  logic [16:0] inc, sum;
  function automatic logic [4:0] f(input logic [4:0] d);
    logic n4, n3, n2, n1, n0;
    n4 = d[4] ^ d[1];
    n3 = d[3] ^ d[0];
    n2 = d[2] ^ n4;
    n1 = d[1] ^ n3;
    n0 = d[0] ^ n2;
    return {n4, n3, n2, n1, n0};
  endfunction
  assign locked = (state == LOCKED);
  always_comb begin
    state_nx  = state;
    seeded_nx = seeded;
    match_nx  = match_cnt;
    miss_nx   = miss_cnt;
    prev_nx   = prev;
    exp_nx    = expected;
    pulse_nx  = 1'b0;
`ifdef LFSR_CHK_BITCNT_EN
    inc = 17'($countones(in_data ^ expected));
`else
    inc = 17'd1;
`endif
    sum    = {1'b0, err_cnt} + inc;
    cnt_nx = err_cnt;
    if (in_valid) begin
      if (state == HUNT) begin
        prev_nx   = in_data;
        seeded_nx = 1'b1;
        // a zero prev never counts, so the all-zero fixed point of f cannot lock
        if (seeded && prev != 5'd0 && in_data == f(prev)) begin
          if (match_cnt == LOCK_LAST) begin
            state_nx = LOCKED;
            exp_nx   = f(in_data);
            miss_nx  = 4'd0;
            match_nx = 4'd0;
          end else begin
            match_nx = match_cnt + 4'd1;
          end
        end else begin
          match_nx = 4'd0;
        end
      end else begin
        exp_nx = f(expected);
        if (in_data == expected) begin
          miss_nx = 4'd0;
        end else begin
          pulse_nx = 1'b1;
          cnt_nx   = sum[16] ? 16'hFFFF : sum[15:0];
          if (miss_cnt == UNLOCK_LAST) begin
            state_nx  = HUNT;
            seeded_nx = 1'b0;
            match_nx  = 4'd0;
            miss_nx   = 4'd0;
          end else begin
            miss_nx = miss_cnt + 4'd1;
          end
        end
      end
    end
    if (clr_cnt) cnt_nx = 16'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= HUNT;
      seeded    <= 1'b0;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      prev      <= 5'd0;
      expected  <= 5'h1F;
      err_pulse <= 1'b0;
      err_cnt   <= 16'd0;
    end else begin
      state     <= state_nx;
      seeded    <= seeded_nx;
      match_cnt <= match_nx;
      miss_cnt  <= miss_nx;
      prev      <= prev_nx;
      expected  <= exp_nx;
      err_pulse <= pulse_nx;
      err_cnt   <= cnt_nx;
    end
  end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: vector table, random stream vs queue-based model, zero stream and saturation runs.
module tb_lfsr_checker;
  localparam int LK = 4;
  localparam int UL = 3;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, in_valid, clr_cnt, locked, err_pulse;
  logic [4:0] in_data;
  logic [15:0] err_cnt;
  logic s_rst_n, s_valid, s_clr, s_locked, s_pulse;
  logic [4:0] s_data;
  logic [15:0] s_cnt;
  lfsr_checker #(.LOCK_CNT(LK), .UNLOCK_CNT(UL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt));
  lfsr_checker #(.LOCK_CNT(1), .UNLOCK_CNT(15)) sat (
    .clk(clk), .rst_n(s_rst_n), .in_valid(s_valid), .in_data(s_data), .clr_cnt(s_clr),
    .locked(s_locked), .err_pulse(s_pulse), .err_cnt(s_cnt));
  int checks = 0;
  int errors = 0;
  bit m_locked, m_pulse;
  logic [4:0] m_exp;
  int m_miss, m_cnt;
  logic [4:0] q[$];
  typedef struct {bit v; bit [4:0] d; bit c; bit r; bit el; bit ep; int ec;} vec_t;
  vec_t tbl[$];
  function automatic logic [4:0] nf(input logic [4:0] d);
    logic [4:0] n;
    n[4] = d[4] ^ d[1];
    n[3] = d[3] ^ d[0];
    n[2] = d[2] ^ n[4];
    n[1] = d[1] ^ n[3];
    n[0] = d[0] ^ n[2];
    return n;
  endfunction
  function automatic vec_t mk(bit v, bit [4:0] d, bit c, bit r, bit el, bit ep, int ec);
    vec_t t;
    t.v = v; t.d = d; t.c = c; t.r = r; t.el = el; t.ep = ep; t.ec = ec;
    return t;
  endfunction
  task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic bit chain_ok();
    for (int i = 0; i < LK; i++)
      if (q[i] == 5'd0 || q[i+1] != nf(q[i])) return 1'b0;
    return 1'b1;
  endfunction
  task automatic model_step(input bit v, input logic [4:0] d, input bit c, input bit r);
    if (!r) begin
      m_locked = 0; m_pulse = 0; m_exp = 5'h1F; m_miss = 0; m_cnt = 0; q.delete();
      return;
    end
    m_pulse = 0;
    if (v) begin
      if (!m_locked) begin
        q.push_back(d);
        if (q.size() > LK + 1) void'(q.pop_front());
        if (q.size() == LK + 1 && chain_ok()) begin
          m_locked = 1; m_exp = nf(d); m_miss = 0; q.delete();
        end
      end else begin
        if (d != m_exp) begin
          m_pulse = 1;
`ifdef LFSR_CHK_BITCNT_EN
          m_cnt += $countones(d ^ m_exp);
`else
          m_cnt += 1;
`endif
          if (m_cnt > 65535) m_cnt = 65535;
          m_miss++;
          if (m_miss == UL) begin m_locked = 0; q.delete(); end
        end else m_miss = 0;
        m_exp = nf(m_exp);
      end
    end
    if (c) m_cnt = 0;
  endtask
  task automatic step(input bit v, input logic [4:0] d, input bit c, input bit r);
    @(negedge clk);
    in_valid = v; in_data = d; clr_cnt = c; rst_n = r;
    @(posedge clk);
    model_step(v, d, c, r);
    #1;
  endtask
  task automatic s_step(input bit v, input logic [4:0] d, input bit c, input bit r);
    @(negedge clk);
    s_valid = v; s_data = d; s_clr = c; s_rst_n = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [4:0] g, e;
    int sc;
    rst_n = 0; in_valid = 0; in_data = 0; clr_cnt = 0;
    s_rst_n = 0; s_valid = 0; s_data = 0; s_clr = 0;
    tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5'h1F, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 5'h06, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 5'h12, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 5'h02, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 5'h17, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 5'h0D, 0, 1, 1, 1, 1));
    tbl.push_back(mk(1, 5'h0F, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 5'h00, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 5'h12, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 5'h09, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 5'h00, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 5'h1F, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 5'h0A, 0, 1, 1, 1, 2));
    tbl.push_back(mk(1, 5'h17, 0, 1, 0, 1, 3));
    tbl.push_back(mk(1, 5'h1F, 0, 1, 0, 0, 3));
    tbl.push_back(mk(1, 5'h06, 0, 1, 0, 0, 3));
    tbl.push_back(mk(1, 5'h12, 0, 1, 0, 0, 3));
    tbl.push_back(mk(0, 5'h00, 0, 1, 0, 0, 3));
    tbl.push_back(mk(1, 5'h02, 0, 1, 0, 0, 3));
    tbl.push_back(mk(1, 5'h17, 0, 1, 1, 0, 3));
    tbl.push_back(mk(1, 5'h0C, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 5'h0C, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5'h1F, 0, 1, 0, 0, 0));
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].r);
      chk($sformatf("vec%0d_locked", i), 17'(locked), 17'(tbl[i].el));
      chk($sformatf("vec%0d_pulse", i), 17'(err_pulse), 17'(tbl[i].ep));
      chk($sformatf("vec%0d_cnt", i), 17'(err_cnt), 17'(tbl[i].ec));
    end
    step(0, 5'h00, 0, 0);
    for (int i = 0; i < 100; i++) begin
      step(1, 5'h00, 0, 1);
      chk("zero_locked", 17'(locked), 17'(0));
    end
    chk("zero_cnt", 17'(err_cnt), 17'(0));
    g = 5'h1F;
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit v, c, rs;
      logic [4:0] d;
      r = $urandom_range(0, 999);
      rs = (r >= 3);
      c = ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 99) >= 15);
      d = ($urandom_range(0, 99) < 85) ? g : 5'($urandom);
      if (v) g = nf(g);
      step(v, d, c, rs);
      chk("rnd_locked", 17'(locked), 17'(m_locked));
      chk("rnd_pulse", 17'(err_pulse), 17'(m_pulse));
      chk("rnd_cnt", 17'(err_cnt), 17'(m_cnt));
    end
    s_step(0, 5'h00, 0, 0);
    s_step(1, 5'h1F, 0, 1);
    s_step(1, 5'h06, 0, 1);
    chk("sat_lock", 17'(s_locked), 17'(1));
    e = 5'h12;
    sc = 0;
    for (int grp = 0; grp < 4682; grp++) begin
      for (int k = 0; k < 14; k++) begin
        s_step(1, e ^ 5'h01, 0, 1);
        e = nf(e);
        sc++;
        if (sc >= 65530) chk("sat_cnt", 17'(s_cnt), 17'(sc > 65535 ? 65535 : sc));
      end
      s_step(1, e, 0, 1);
      e = nf(e);
    end
    chk("sat_locked", 17'(s_locked), 17'(1));
    chk("sat_hold", 17'(s_cnt), 17'(16'hFFFF));
    s_step(1, e ^ 5'h01, 1, 1);
    chk("sat_clr_cnt", 17'(s_cnt), 17'(0));
    chk("sat_clr_pulse", 17'(s_pulse), 17'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter: LOCK_CNT, 4, consecutive predicted-word matches needed to enter LOCKED (range 1..15).
REQ-002 SHALL have parameter: UNLOCK_CNT, 3, consecutive mismatches in LOCKED that force return to HUNT (range 1..15).
REQ-003 SHALL have port: clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: in_valid  input  1  in_data carries a stream word this cycle.
REQ-006 SHALL have port: in_data  input  5  received 5-bit pseudo-random word.
REQ-007 SHALL have port: clr_cnt  input  1  synchronous clear of err_cnt.
REQ-008 SHALL have port: locked  output  1  checker is in LOCKED.
REQ-009 SHALL have port: err_pulse  output  1  one-cycle flag for a mismatching word in LOCKED.
REQ-010 SHALL have port: err_cnt  output  16  saturating error count.

Function
REQ-011 SHALL define next-word map f(d): n4=d4^d1; n3=d3^d0; n2=d2^n4; n1=d1^n3; n0=d0^n2.
REQ-012 SHALL implement two states: HUNT and LOCKED; all outputs registered.
REQ-013 SHALL ignore all inputs except rst_n and clr_cnt in cycles with in_valid=0; state, counters and stored words hold.
REQ-014 In HUNT, first valid word after entry SHALL only be stored as prev (seeded flag set); match_cnt=0.
REQ-015 In HUNT with seeded, each valid word SHALL increment match_cnt if prev!=0 and in_data==f(prev), else set match_cnt=0; prev<=in_data always.
REQ-016 When match_cnt would reach LOCK_CNT, SHALL go to LOCKED next cycle with expected<=f(in_data), miss_cnt=0.
REQ-017 In HUNT, err_pulse SHALL stay 0 and err_cnt SHALL not increment.
REQ-018 In LOCKED, each valid word SHALL be compared with expected; expected<=f(expected) regardless of result (no resync).
REQ-019 On LOCKED match, miss_cnt SHALL clear; on mismatch, err_pulse=1 the following cycle, err_cnt increments, miss_cnt increments.
REQ-020 When miss_cnt would reach UNLOCK_CNT, SHALL return to HUNT next cycle with seeded=0, match_cnt=0; locked drops same cycle.
REQ-021 err_cnt SHALL saturate at 16'hFFFF, never wrap.
REQ-022 clr_cnt=1 SHALL set err_cnt=0 next cycle; clear wins over a simultaneous increment; err_pulse unaffected.
REQ-023 locked SHALL equal (state==LOCKED); err_pulse SHALL be 0 whenever no mismatch was registered the prior valid cycle.
REQ-024 All-zero input stream SHALL never achieve lock.

Reset
REQ-025 On rising clk with rst_n=0: state=HUNT, seeded=0, match_cnt=0, miss_cnt=0, prev=0, expected=5'h1F, locked=0, err_pulse=0, err_cnt=0.
REQ-026 Reset SHALL take priority over in_valid and clr_cnt, including mid-LOCKED.

Configuration
REQ-027 Macro LFSR_CHK_BITCNT_EN defined: each mismatch SHALL add popcount(in_data^expected) (1..5) to err_cnt, saturating at 16'hFFFF.
REQ-028 Macro LFSR_CHK_BITCNT_EN undefined: each mismatch SHALL add exactly 1 to err_cnt.

Verification
REQ-029 Reset, stream 1F,06,12,02,17 valid back-to-back -> locked=1 cycle after 17 accepted; err_cnt=0.
REQ-030 After REQ-029, send 0D (expected 0C) -> err_pulse=1 for one cycle, err_cnt=1 (both macro settings), locked stays 1.
REQ-031 Locked, send 3 consecutive corrupt words -> err_cnt=3 (word mode), locked=0 after third; correct stream resumes -> relock after seed+4 matches.
REQ-032 Continuous in_data=00, in_valid=1 for 100 cycles -> locked never asserts, err_cnt=0.
REQ-033 Locked, clr_cnt=1 in same cycle as mismatch -> err_cnt=0 next cycle, err_pulse=1; err_cnt preload near FFFF -> holds FFFF.
REQ-034 Locked, rst_n=0 one cycle with in_valid=1 -> locked=0, err_cnt=0, err_pulse=0 next cycle; gaps in in_valid mid-stream do not affect lock.
